if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_pkg.sv | 10 +
 rtl/fetch_fifo2.sv | 29 ++
 rtl/if_fetch_stage.sv | 73 +++++++
 tb/tb_if_fetch_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared constants and the fetch-buffer entry type for the IF stage.
package if_fetch_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int BUF_DEPTH = 2;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: 2-entry instr/pc buffer with push, pop and flush.
module fetch_fifo2 import if_fetch_stage_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);
  fetch_entry_t mem_q [2];
  logic rd_q, wr_q;
  logic [1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst || flush_i) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q <= rd_q ^ pop_i;
      wr_q <= wr_q ^ push_i;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, single-outstanding imem fetch and buffered instr/pc handoff to ID.
module if_fetch_stage import if_fetch_stage_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic out_q, out_d, drop_q, drop_d;
  logic fire, rsp_take, push, pop;
  logic [1:0] count;
  fetch_entry_t head, push_entry;
  // A buffer slot is reserved at issue, so a returning response always has room.
  assign imem_req_valid = !rst && !halt && !redirect_valid && !out_q &&
                          ((count + 2'(out_q)) < 2'(BUF_DEPTH));
  assign imem_req_addr = pc_q;
  assign fire = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && out_q;
  assign push = rsp_take && !drop_q && !redirect_valid;
  assign push_entry = '{instr: imem_rsp_data, pc: req_pc_q};
  assign id_valid = count != 2'd0;
  assign pop = id_valid && id_ready;
  always_comb begin
    pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : fire ? pc_q + 32'd4 : pc_q;
    req_pc_d = fire ? pc_q : req_pc_q;
    out_d = fire || (out_q && !imem_rsp_valid);
    drop_d = redirect_valid ? out_q && !imem_rsp_valid : drop_q && !rsp_take;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc_q <= RESET_PC;
      req_pc_q <= RESET_PC;
      out_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  fetch_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_entry),
    .head_o      (head),
    .count_o     (count)
  );
  assign id_instr = id_valid ? head.instr : '0;
  assign id_pc = id_valid ? head.pc : '0;
  assign id_pc_plus4 = id_valid ? head.pc + 32'd4 : '0;
  always_ff @(posedge clk)
    if (!rst) begin
      assert (!(push && count == 2'd2));
      assert (!(fire && out_q));
      assert (imem_req_addr[1:0] == 2'b00);
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench with a latency-configurable imem model.
module tb_if_fetch_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic redirect_valid = 1'b0, halt = 1'b0, id_ready = 1'b1, imem_req_ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_instr, id_pc, id_pc_plus4;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int mem_cnt = 0, lat = 1, checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory answers lat cycles after acceptance; lat=1 means valid in the very next cycle.
  always @(posedge clk)
    if (rst) begin
      mem_busy <= 1'b0;
      imem_rsp_valid <= 1'b0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data <= word(mem_addr);
          mem_busy <= 1'b0;
        end else mem_cnt <= mem_cnt - 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_addr <= imem_req_addr;
        if (lat == 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data <= word(imem_req_addr);
        end else begin
          mem_busy <= 1'b1;
          mem_cnt <= lat - 1;
        end
      end
    end

  always @(negedge clk) begin
    #2;
    if (!rst && !redirect_valid && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_id: got pc %h with empty scoreboard", id_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e);
        chk("id_instr", id_instr, word(e));
        chk("id_pc_plus4", id_pc_plus4, e + 32'd4);
      end
    end
  end

  task automatic push_seq(input logic [31:0] start);
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic redirect(input logic [31:0] pc, input logic [31:0] start);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    exp_q.delete();
    push_seq(start);
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_fire(input string nm, input logic [31:0] exp);
    for (int i = 0; i < 60; i++) begin
      #2;
      if (imem_req_valid && imem_req_ready) begin
        chk(nm, imem_req_addr, exp);
        return;
      end
      @(negedge clk);
    end
    chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_seq(32'h8000_0000);
    #2;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    repeat (12) @(negedge clk);
    // ID stall: buffer fills to two entries, then fetch stops and the head holds.
    id_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (c >= 3) begin
        chk("stall_id_valid", 32'(id_valid), 32'd1);
        chk("stall_id_pc", id_pc, exp_q.size() != 0 ? exp_q[0] : 32'hDEAD_BEEF);
        chk("stall_id_instr", id_instr, exp_q.size() != 0 ? word(exp_q[0]) : 32'hDEAD_BEEF);
      end
      if (c >= 4) chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
    end
    id_ready = 1'b1;
    repeat (10) @(negedge clk);
    // Mid-run reset, then 3-cycle memory with a redirect while 0x8000_0010 is in flight.
    rst = 1'b1;
    lat = 3;
    exp_q.delete();
    #2;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    #2;
    chk("midrst_id_valid", 32'(id_valid), 32'd0);
    chk("midrst_id_pc", id_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_seq(32'h8000_0000);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = mem_busy && mem_addr == 32'h8000_0010;
    end
    chk("inflight_0x10_seen", 32'(found), 32'd1);
    redirect(32'h8000_0100, 32'h8000_0100);
    wait_fire("redir_req_addr", 32'h8000_0100);
    repeat (12) @(negedge clk);
    // Redirect coinciding with a response: data is discarded, no stale drop lingers.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = imem_rsp_valid;
    end
    chk("rsp_seen", 32'(found), 32'd1);
    redirect(32'h8000_0200, 32'h8000_0200);
    wait_fire("samecyc_req_addr", 32'h8000_0200);
    repeat (16) @(negedge clk);
    lat = 1;
    redirect(32'h8000_0206, 32'h8000_0204);
    wait_fire("misalign_req_addr", 32'h8000_0204);
    repeat (10) @(negedge clk);
    redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    wait_fire("wrap_addr0", 32'hFFFF_FFF8);
    @(negedge clk);
    wait_fire("wrap_addr1", 32'hFFFF_FFFC);
    @(negedge clk);
    wait_fire("wrap_addr2", 32'h0000_0000);
    repeat (8) @(negedge clk);
    // Halt with one request outstanding: it still lands in ID, nothing new issues.
    lat = 3;
    redirect(32'h8000_0300, 32'h8000_0300);
    wait_fire("halt_pre_addr", 32'h8000_0300);
    @(negedge clk);
    halt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("halt_no_req", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
    end
    chk("halt_delivered", exp_q.size() != 0 ? exp_q[0] : 32'hDEAD_BEEF, 32'h8000_0304);
    halt = 1'b0;
    wait_fire("resume_addr", 32'h8000_0304);
    @(negedge clk);
    halt = 1'b1;
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
